// File: rtl/uart_pkg.sv
// Shared UART receive-path types.
// State encoding and counter limits.
package uart_pkg;

  typedef enum logic [1:0] {
    FILL,
    WRITE,
    FULL
  } state_e;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/uart_rx_word_packer.sv
// Packs received UART bytes into little-endian words
// and writes them to memory at incrementing addresses.
module uart_rx_word_packer
  import uart_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int MEM_DEPTH  = 64,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_data_valid,
  input  logic [7:0]            rx_data,
  input  logic                  rx_par_err,
  input  logic                  rx_stp_err,
  input  logic                  flush,
  input  logic                  clear,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH:0]   word_cnt,
  output logic [7:0]            err_cnt,
  output logic                  full,
  output logic                  overflow
);

  localparam int BPW = DATA_WIDTH / 8;
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [IW-1:0] LAST_IDX =
    IW'(BPW - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] LAST_CNT =
    (ADDR_WIDTH + 1)'(MEM_DEPTH - 1);

  state_e state_q, state_d;

  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] lanes_q, lanes_d;
  logic [DATA_WIDTH-1:0] lane_word;

  logic                  wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_d;
  logic [ADDR_WIDTH:0]   word_cnt_d;
  logic [7:0]            err_cnt_d;
  logic                  full_d;
  logic                  overflow_d;

  logic blocked;
  logic byte_err;
  logic accept;
  logic err_hit;
  logic ovf_hit;
  logic word_done;
  logic flush_eff;
  logic do_write;
  logic last_write;

  // Classify the incoming byte and decide if a write is due
  always_comb begin
    blocked   = (state_q == FULL);
    byte_err  = rx_par_err | rx_stp_err;
    accept    = rx_data_valid & ~byte_err & ~blocked;
    err_hit   = rx_data_valid & byte_err & ~blocked;
    ovf_hit   = rx_data_valid & blocked;
    word_done = accept & (idx_q == LAST_IDX);
    flush_eff = flush & ~blocked
              & ((idx_q != '0) | accept);
    do_write  = word_done | flush_eff;
    last_write = (state_q == WRITE)
               & (word_cnt == LAST_CNT);
    lane_word = lanes_q;
    if (accept) begin
      lane_word[8*idx_q +: 8] = rx_data;
    end
  end

  // Next state: fill, one-cycle write, or blocked when full
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: begin
        if (do_write) state_d = WRITE;
      end
      WRITE: begin
        if (last_write)    state_d = FULL;
        else if (do_write) state_d = WRITE;
        else               state_d = FILL;
      end
      FULL: state_d = FULL;
      default: state_d = FILL;
    endcase
    if (clear) state_d = FILL;
  end

  // Next values for lanes, pointer, counters and flags
  always_comb begin
    idx_d      = idx_q;
    lanes_d    = lane_word;
    wr_data_d  = wr_data;
    wr_addr_d  = wr_addr;
    word_cnt_d = word_cnt;
    err_cnt_d  = err_cnt;
    overflow_d = overflow | ovf_hit;
    if (accept) idx_d = idx_q + 1'b1;
    if (do_write) begin
      idx_d     = '0;
      lanes_d   = '0;
      wr_data_d = lane_word;
    end
    if (state_q == WRITE) begin
      wr_addr_d  = (wr_addr == LAST_ADDR) ? '0
                 : wr_addr + 1'b1;
      word_cnt_d = word_cnt + 1'b1;
    end
    if (err_hit && err_cnt != ERR_CNT_MAX) begin
      err_cnt_d = err_cnt + 8'd1;
    end
    wr_en_d = (state_d == WRITE);
    full_d  = (state_d == FULL);
    if (clear) begin
      idx_d      = '0;
      lanes_d    = '0;
      wr_data_d  = '0;
      wr_addr_d  = '0;
      word_cnt_d = '0;
      err_cnt_d  = '0;
      overflow_d = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      lanes_q  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      word_cnt <= '0;
      err_cnt  <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      lanes_q  <= lanes_d;
      wr_en    <= wr_en_d;
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
      word_cnt <= word_cnt_d;
      err_cnt  <= err_cnt_d;
      full     <= full_d;
      overflow <= overflow_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Directed bench for uart_rx_word_packer.
// Hand-computed expectations, immediate assertions.
module tb_uart_rx_word_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_data_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_par_err = 1'b0;
  logic        rx_stp_err = 1'b0;
  logic        flush = 1'b0;
  logic        clear = 1'b0;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [6:0]  word_cnt;
  logic [7:0]  err_cnt;
  logic        full;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  int wr_seen = 0;
  int wr_mark = 0;

  uart_rx_word_packer #(
    .DATA_WIDTH(32),
    .MEM_DEPTH(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data_valid(rx_data_valid),
    .rx_data(rx_data),
    .rx_par_err(rx_par_err),
    .rx_stp_err(rx_stp_err),
    .flush(flush),
    .clear(clear),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .word_cnt(word_cnt),
    .err_cnt(err_cnt),
    .full(full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en === 1'b1) wr_seen++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v,
                       input logic [7:0] d,
                       input logic p,
                       input logic s,
                       input logic f,
                       input logic c);
    rx_data_valid = v;
    rx_data       = d;
    rx_par_err    = p;
    rx_stp_err    = s;
    flush         = f;
    clear         = c;
    @(posedge clk);
    #1;
    rx_data_valid = 1'b0;
    rx_data       = 8'h00;
    rx_par_err    = 1'b0;
    rx_stp_err    = 1'b0;
    flush         = 1'b0;
    clear         = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_word_cnt", 64'(word_cnt), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    idle();

    // one full word
    send(8'h11);
    send(8'h22);
    send(8'h33);
    chk("w1_no_early_wr", 64'(wr_en), 64'd0);
    send(8'h44);
    chk("w1_wr_en", 64'(wr_en), 64'd1);
    chk("w1_addr", 64'(wr_addr), 64'd0);
    chk("w1_data", 64'(wr_data), 64'h44332211);
    idle();
    chk("w1_wr_en_off", 64'(wr_en), 64'd0);
    chk("w1_word_cnt", 64'(word_cnt), 64'd1);
    chk("w1_addr_inc", 64'(wr_addr), 64'd1);

    // flush of partial word
    do_clear();
    chk("clr_word_cnt", 64'(word_cnt), 64'd0);
    chk("clr_addr", 64'(wr_addr), 64'd0);
    send(8'hAA);
    send(8'hBB);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("fl_wr_en", 64'(wr_en), 64'd1);
    chk("fl_addr", 64'(wr_addr), 64'd0);
    chk("fl_data", 64'(wr_data), 64'h0000BBAA);
    idle();
    wr_mark = wr_seen;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("fl2_wr_en", 64'(wr_en), 64'd0);
    idle();
    chk("fl2_no_write", 64'(wr_seen), 64'(wr_mark));
    chk("fl2_word_cnt", 64'(word_cnt), 64'd1);
    drive(1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flb_wr_en", 64'(wr_en), 64'd1);
    chk("flb_addr", 64'(wr_addr), 64'd1);
    chk("flb_data", 64'(wr_data), 64'h000000CC);
    idle();
    chk("flb_once", 64'(wr_seen), 64'(wr_mark + 1));
    chk("flb_word_cnt", 64'(word_cnt), 64'd2);

    // parity and stop-bit errors
    do_clear();
    send(8'h01);
    send(8'h02);
    drive(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pe_err_cnt", 64'(err_cnt), 64'd1);
    send(8'h03);
    send(8'h04);
    chk("pe_data", 64'(wr_data), 64'h04030201);
    chk("pe_addr", 64'(wr_addr), 64'd0);
    idle();
    chk("pe_err_hold", 64'(err_cnt), 64'd1);
    send(8'h01);
    send(8'h02);
    drive(1'b1, 8'hDD, 1'b0, 1'b1, 1'b0, 1'b0);
    send(8'h03);
    send(8'h04);
    chk("se_wr_en", 64'(wr_en), 64'd1);
    chk("se_data", 64'(wr_data), 64'h04030201);
    chk("se_addr", 64'(wr_addr), 64'd1);
    idle();
    chk("se_err_cnt", 64'(err_cnt), 64'd2);

    // fill the memory
    do_clear();
    wr_mark = wr_seen;
    for (int i = 0; i < 256; i++) send(8'(i));
    chk("fm_last_wr", 64'(wr_en), 64'd1);
    chk("fm_last_addr", 64'(wr_addr), 64'd63);
    chk("fm_last_data", 64'(wr_data), 64'hFFFEFDFC);
    chk("fm_not_full_yet", 64'(full), 64'd0);
    idle();
    chk("fm_full", 64'(full), 64'd1);
    chk("fm_word_cnt", 64'(word_cnt), 64'd64);
    chk("fm_addr_wrap", 64'(wr_addr), 64'd0);
    chk("fm_writes", 64'(wr_seen), 64'(wr_mark + 64));
    send(8'h5A);
    chk("ov_no_wr", 64'(wr_en), 64'd0);
    chk("ov_flag", 64'(overflow), 64'd1);
    idle();
    chk("ov_sticky", 64'(overflow), 64'd1);
    chk("ov_err_cnt", 64'(err_cnt), 64'd0);
    chk("ov_writes", 64'(wr_seen), 64'(wr_mark + 64));
    do_clear();
    chk("cl_full", 64'(full), 64'd0);
    chk("cl_overflow", 64'(overflow), 64'd0);
    chk("cl_word_cnt", 64'(word_cnt), 64'd0);

    // reset mid-word
    send(8'h10);
    send(8'h20);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    idle();
    wr_mark = wr_seen;
    send(8'h31);
    send(8'h32);
    send(8'h33);
    send(8'h34);
    chk("rm_wr_en", 64'(wr_en), 64'd1);
    chk("rm_addr", 64'(wr_addr), 64'd0);
    chk("rm_data", 64'(wr_data), 64'h34333231);
    idle();
    chk("rm_once", 64'(wr_seen), 64'(wr_mark + 1));

    // error counter saturation
    wr_mark = wr_seen;
    for (int i = 0; i < 254; i++)
      drive(1'b1, 8'h77, i[0], ~i[0], 1'b0, 1'b0);
    chk("sat_254", 64'(err_cnt), 64'd254);
    for (int i = 0; i < 46; i++)
      drive(1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    chk("sat_255", 64'(err_cnt), 64'd255);
    chk("sat_no_wr", 64'(wr_seen), 64'(wr_mark));
    chk("sat_word_cnt", 64'(word_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_word_packer.md
# uart_rx_word_packer

Packs the 8-bit byte stream produced by the UART receiver into DATA_WIDTH-bit little-endian words and writes them into the second memory at auto-incrementing addresses. It sits directly downstream of the UART receiver, consuming its data-valid, data and error outputs. It drives the memory write port: write enable, address and data-in.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- MEM_DEPTH, 64, number of memory words; sets the wrap/full point.
- ADDR_WIDTH, localparam $clog2(MEM_DEPTH), write address width.

Ports:
- clk  in  1  single clock, shared with the memory.
- rst  in  1  asynchronous reset, active-high.
- rx_data_valid  in  1  one-cycle pulse per received byte.
- rx_data  in  8  received byte, valid with rx_data_valid.
- rx_par_err  in  1  parity error for the byte in the same cycle.
- rx_stp_err  in  1  stop-bit error for the byte in the same cycle.
- flush  in  1  pulse; zero-pad and write the pending partial word.
- clear  in  1  synchronous pulse; reset pointer, byte index, flags and counters.
- wr_en  out  1  memory write strobe, one cycle per word.
- wr_addr  out  ADDR_WIDTH  memory write address.
- wr_data  out  DATA_WIDTH  packed word.
- word_cnt  out  ADDR_WIDTH+1  words written since reset/clear.
- err_cnt  out  8  bytes dropped due to errors, saturates at 255.
- full  out  1  MEM_DEPTH words written; further writes blocked.
- overflow  out  1  sticky; a byte arrived while full.

## Operation
- BPW = DATA_WIDTH/8 bytes per word. byte_idx counts 0..BPW-1.
- Byte acceptance requires all of: rx_data_valid=1, rx_par_err=0, rx_stp_err=0, full=0.
- An accepted byte goes to lane byte_idx, bits [8*byte_idx+7 : 8*byte_idx]. The first byte lands in bits [7:0].
- Error byte: discarded; err_cnt increments (saturating at 255); byte_idx and the partial word are unchanged.
- Byte arriving while full=1: discarded; overflow is set and stays set; err_cnt is unchanged.
- Completing a word: when the accepted byte fills lane BPW-1, the word is presented on wr_data/wr_addr and wr_en is pulsed. byte_idx returns to 0 and the lane register is zeroed.
- Flush: if flush=1 and byte_idx>0, the pending word is written with unfilled lanes set to 0. If byte_idx=0, flush has no effect.
- Flush together with a valid byte: the byte is accepted first. The resulting word (complete or padded) is written once.
- After each write: wr_addr increments, wrapping at MEM_DEPTH-1 → 0, and word_cnt increments.
- full sets when word_cnt reaches MEM_DEPTH.
- Priority order: rst > clear > byte/flush processing.
- clear zeroes the pointer, byte_idx, lanes, word_cnt, err_cnt, full and overflow. A byte in the same cycle as clear is dropped.
- FSM state_e has three states:
  - FILL: collecting bytes.
  - WRITE: one cycle, wr_en=1.
  - FULL: blocked.
- FSM transitions:
  - FILL → WRITE on word completion or an effective flush.
  - WRITE → FULL if the new word_cnt = MEM_DEPTH, otherwise → FILL.
  - FULL → FILL only on clear.
- A valid byte arriving while in WRITE is accepted as lane 0 of the next word.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, word_cnt=0, err_cnt=0, full=0, overflow=0; FSM in FILL, byte_idx=0.
- Reset asserted mid-word discards the partial word; no write is issued.
- All outputs are registered.
- wr_en is high exactly one cycle, in the cycle after the completing byte (or the effective flush) is sampled. wr_data and wr_addr are stable during that cycle.
- wr_addr and word_cnt update in the cycle after wr_en. full rises in that same cycle.
- err_cnt updates one cycle after the errored byte is sampled.
- Throughput: one byte per cycle is sustained; back-to-back rx_data_valid pulses are all accepted.

## Structure
- Shared package uart_pkg holds:
  - typedef enum logic [1:0] state_e {FILL, WRITE, FULL};
  - localparam ERR_CNT_MAX = 8'hFF.
- BPW is derived inside the module from DATA_WIDTH.
- Single module, no sub-module. The lane register, FSM and counters together are about 150–200 lines.

## Test plan
- Bytes 0x11, 0x22, 0x33, 0x44 → one wr_en pulse with wr_addr=0, wr_data=0x44332211; then word_cnt=1, wr_addr=1.
- Bytes 0xAA, 0xBB, then flush → wr_data=0x0000BBAA at addr 0. A second flush issues no write.
- Bytes 0x01, 0x02, a byte with rx_par_err=1, then 0x03, 0x04 → wr_data=0x04030201 and err_cnt=1. Repeat with rx_stp_err=1 → err_cnt=2.
- 64 full words → full=1 after the 64th write, wr_addr wrapped to 0. A further byte → no wr_en, overflow=1. clear → full=0, overflow=0, word_cnt=0.
- Bytes 0x10, 0x20, rst pulse, then 0x31, 0x32, 0x33, 0x34 → single write of 0x34333231 at addr 0.
- 300 errored bytes → err_cnt saturates at 255; no writes issued.
